multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control state machine for the multicycle RV32I core. It sequences the shared ALU, register file, instruction register and unified memory port across instruction phases. Each cycle it drives the mux selects, write enables and the 2-bit `ALUOp` consumed by the ALU decoder. It stalls on a memory-ready handshake and flags unsupported opcodes.

## Interface
Parameters: none; opcodes fixed to RV32I (lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, jal 1101111, beq 1100011).

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `op`  in  7  opcode from instruction register (valid from DECODE onward)
- `Zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes current access this cycle
- `PCWrite`  out  1  PC register enable
- `AdrSrc`  out  1  memory address: 0 = PC, 1 = Result
- `MemWrite`  out  1  memory write strobe
- `IRWrite`  out  1  instruction/OldPC register enable
- `ResultSrc`  out  2  00 ALUOut, 01 Data, 10 ALUResult
- `ALUSrcA`  out  2  00 PC, 01 OldPC, 10 rs1 (A)
- `ALUSrcB`  out  2  00 rs2, 01 ImmExt, 10 constant 4
- `ALUOp`  out  2  00 add, 01 subtract (branch), 10 funct-decoded
- `RegWrite`  out  1  register file write enable
- `instr_done`  out  1  one-cycle pulse when an instruction retires
- `illegal_op`  out  1  one-cycle pulse, unsupported opcode in DECODE
- `state_o`  out  4  current state encoding (debug)

## Operation
- Moore FSM, 4-bit state register. Outputs decode combinationally from state; the exceptions are `PCWrite` (uses `Zero`) and the FETCH/MEM enables gated by `mem_ready`.
- Listed signals take the stated values; unlisted enables are 0 and unlisted selects are 00.
- Binary encodings S0..S10:
  - S0 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=1 and PCUpdate=1 only when mem_ready=1. Advances to DECODE when mem_ready=1, otherwise holds.
  - S1 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by `op`:
    - lw/sw → MEMADR
    - R → EXECR
    - I-ALU → EXECI
    - jal → JAL
    - beq → BEQ
    - any other opcode → FETCH with illegal_op=1
  - S2 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next is MEMREAD if op=lw, else MEMWRITE.
  - S3 MEMREAD: ResultSrc=00, AdrSrc=1. Holds until mem_ready, then MEMWB.
  - S4 MEMWB: ResultSrc=01, RegWrite=1, instr_done=1. Next is FETCH.
  - S5 MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 for every cycle in state. Holds until mem_ready; on that cycle instr_done=1, next is FETCH.
  - S6 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next is ALUWB.
  - S7 ALUWB: ResultSrc=00, RegWrite=1, instr_done=1. Next is FETCH.
  - S8 EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next is ALUWB.
  - S9 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next is ALUWB.
  - S10 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, instr_done=1. Next is FETCH.
- PCWrite = PCUpdate | (Branch & Zero).
- Unused encodings 11–15 return to FETCH next cycle with all enables 0.

## Timing
- Reset: while rst=1 the state is forced to FETCH on the edge. During rst=1, PCWrite, MemWrite, IRWrite, RegWrite, instr_done and illegal_op are forced to 0; selects take FETCH values. The first fetch is the first cycle after rst deasserts.
- Reset mid-instruction aborts the instruction; no write enable asserts in the reset cycle.
- Latency with mem_ready=1 (FETCH to final state inclusive):
  - lw: 5 cycles
  - sw: 4 cycles
  - R/I-ALU: 4 cycles
  - jal: 4 cycles
  - beq: 3 cycles
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. Stall cycles have IRWrite=PCWrite=RegWrite=0.
- `op` is sampled only in DECODE and MEMADR; changes elsewhere are ignored.
- instr_done asserts exactly once per retired instruction; an illegal opcode retires nothing.

## Test plan
- Reset: rst=1 for 2 cycles mid-MEMWRITE → MemWrite=0 during reset; state_o=0 the cycle after rst falls.
- add (op=0110011), mem_ready=1 → states 0,1,6,7; ALUOp=10 in S6; RegWrite=1 and instr_done=1 in cycle 4.
- lw (op=0000011), mem_ready low for 2 cycles in MEMREAD → states 0,1,2,3,3,3,4; RegWrite only in S4, ResultSrc=01.
- beq (op=1100011): Zero=1 → PCWrite=1 in S10. Zero=0 → PCWrite=0. Both cases return to FETCH.
- FETCH with mem_ready=0 for 3 cycles → IRWrite=PCWrite=0 for those cycles, then both 1 for exactly one cycle.
- Illegal op=0000000 → illegal_op pulse in DECODE, next state FETCH, no RegWrite/MemWrite/instr_done.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core. It sequences the shared ALU, register file,
// instruction register and memory port, stalls on mem_ready and flags unsupported opcodes.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegWrite,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state_o
);
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    state_t state;
    logic   pc_update;
    logic   branch;
    logic   op_legal;

    assign state_o  = state;
    assign op_legal = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                      (op == OP_I) || (op == OP_JAL) || (op == OP_BEQ);

    // State sequencing; op only matters in DECODE and MEMADR.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:    if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_R:         state <= S_EXECR;
                        OP_I:         state <= S_EXECI;
                        OP_JAL:       state <= S_JAL;
                        OP_BEQ:       state <= S_BEQ;
                        default:      state <= S_FETCH;
                    endcase
                end
                S_MEMADR:   state <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: if (mem_ready) state <= S_FETCH;
                S_EXECR:    state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_EXECI:    state <= S_ALUWB;
                S_JAL:      state <= S_ALUWB;
                S_BEQ:      state <= S_FETCH;
                default:    state <= S_FETCH;
            endcase
        end
    end

    // Moore decode; reset holds FETCH selects with every enable low.
    always_comb begin
        pc_update  = 1'b0;
        branch     = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        RegWrite   = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        if (rst) begin
            ResultSrc = 2'b10;
            ALUSrcB   = 2'b10;
        end else begin
            case (state)
                S_FETCH: begin
                    ResultSrc = 2'b10;
                    ALUSrcB   = 2'b10;
                    IRWrite   = mem_ready;
                    pc_update = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcA    = 2'b01;
                    ALUSrcB    = 2'b01;
                    illegal_op = !op_legal;
                end
                S_MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                end
                S_MEMREAD:  AdrSrc = 1'b1;
                S_MEMWB: begin
                    ResultSrc  = 2'b01;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWRITE: begin
                    AdrSrc     = 1'b1;
                    MemWrite   = 1'b1;
                    instr_done = mem_ready;
                end
                S_EXECR: begin
                    ALUSrcA = 2'b10;
                    ALUOp   = 2'b10;
                end
                S_ALUWB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_EXECI: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    ALUOp   = 2'b10;
                end
                S_JAL: begin
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    pc_update = 1'b1;
                end
                S_BEQ: begin
                    ALUSrcA    = 2'b10;
                    ALUOp      = 2'b01;
                    branch     = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
        PCWrite = pc_update | (branch & Zero);
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a per-instruction phase-sequence model builds a cycle trace of
// inputs and expected states, and one process compares every DUT output against it each cycle.
module tb_multicycle_ctrl;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RR  = 7'b0110011;
    localparam logic [6:0] II  = 7'b0010011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] BEQ = 7'b1100011;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'd0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal_op;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [3:0] state_o;

    int total = 0;
    int bad = 0;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .RegWrite(RegWrite), .instr_done(instr_done), .illegal_op(illegal_op),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [6:0] o;
        logic       z;
        logic       mr;
        logic [3:0] st;
    } cyc_t;

    cyc_t trace[$];

    task automatic push(input logic r, input logic [6:0] o, input logic z,
                        input logic mr, input logic [3:0] st);
        cyc_t c;
        c.r = r; c.o = o; c.z = z; c.mr = mr; c.st = st;
        trace.push_back(c);
    endtask

    // Phase sequence of one instruction; op is garbage outside DECODE/MEMADR.
    task automatic instr(input logic [6:0] o, input logic z, input int fst, input int mst,
                         output int n);
        int b;
        b = trace.size();
        for (int i = 0; i < fst; i++) push(1'b0, ~o, z, 1'b0, 4'd0);
        push(1'b0, ~o, z, 1'b1, 4'd0);
        push(1'b0, o, z, 1'b1, 4'd1);
        if (o == LW) begin
            push(1'b0, o, z, 1'b1, 4'd2);
            for (int i = 0; i < mst; i++) push(1'b0, ~o, z, 1'b0, 4'd3);
            push(1'b0, ~o, z, 1'b1, 4'd3);
            push(1'b0, ~o, z, 1'b0, 4'd4);
        end else if (o == SW) begin
            push(1'b0, o, z, 1'b1, 4'd2);
            for (int i = 0; i < mst; i++) push(1'b0, ~o, z, 1'b0, 4'd5);
            push(1'b0, ~o, z, 1'b1, 4'd5);
        end else if (o == RR) begin
            push(1'b0, ~o, z, 1'b1, 4'd6);
            push(1'b0, ~o, z, 1'b0, 4'd7);
        end else if (o == II) begin
            push(1'b0, ~o, z, 1'b1, 4'd8);
            push(1'b0, ~o, z, 1'b1, 4'd7);
        end else if (o == JAL) begin
            push(1'b0, ~o, z, 1'b1, 4'd9);
            push(1'b0, ~o, z, 1'b1, 4'd7);
        end else if (o == BEQ) begin
            push(1'b0, ~o, z, 1'b1, 4'd10);
        end
        n = trace.size() - b;
    endtask

    // Expected output vector {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,
    // RegWrite,instr_done,illegal_op} from the per-state output table.
    function automatic logic [14:0] exp_out(input cyc_t c);
        logic pcw, adr, mw, irw, rw, dn, il;
        logic [1:0] res, sa, sb, aop;
        logic legal;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; dn = 0; il = 0;
        res = 2'd0; sa = 2'd0; sb = 2'd0; aop = 2'd0;
        legal = (c.o == LW) || (c.o == SW) || (c.o == RR) || (c.o == II) ||
                (c.o == JAL) || (c.o == BEQ);
        if (c.r) begin
            res = 2'd2; sb = 2'd2;
        end else begin
            case (c.st)
                4'd0:  begin res = 2'd2; sb = 2'd2; irw = c.mr; pcw = c.mr; end
                4'd1:  begin sa = 2'd1; sb = 2'd1; il = !legal; end
                4'd2:  begin sa = 2'd2; sb = 2'd1; end
                4'd3:  adr = 1'b1;
                4'd4:  begin res = 2'd1; rw = 1'b1; dn = 1'b1; end
                4'd5:  begin adr = 1'b1; mw = 1'b1; dn = c.mr; end
                4'd6:  begin sa = 2'd2; aop = 2'd2; end
                4'd7:  begin rw = 1'b1; dn = 1'b1; end
                4'd8:  begin sa = 2'd2; sb = 2'd1; aop = 2'd2; end
                4'd9:  begin sa = 2'd1; sb = 2'd2; pcw = 1'b1; end
                4'd10: begin sa = 2'd2; aop = 2'd1; dn = 1'b1; pcw = c.z; end
                default: ;
            endcase
        end
        return {pcw, adr, mw, irw, res, sa, sb, aop, rw, dn, il};
    endfunction

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    initial begin
        int n;
        int retired;
        int illegals;
        cyc_t pin;
        logic [14:0] act;
        logic [14:0] exp;

        // Model pins: hand-computed latencies and one hand-computed output vector.
        push(1'b1, 7'd0, 1'b0, 1'b1, 4'd0);
        push(1'b1, 7'd0, 1'b0, 1'b1, 4'd0);
        instr(RR, 1'b1, 0, 0, n);  check("len_add", n, 4);
        instr(LW, 1'b0, 0, 2, n);  check("len_lw_stall2", n, 7);
        instr(BEQ, 1'b1, 0, 0, n); check("len_beq_z1", n, 3);
        instr(BEQ, 1'b0, 0, 0, n); check("len_beq_z0", n, 3);
        instr(RR, 1'b0, 3, 0, n);  check("len_add_fetch_stall3", n, 7);
        instr(7'b0000000, 1'b0, 0, 0, n); check("len_illegal", n, 2);
        instr(II, 1'b1, 0, 0, n);  check("len_iali", n, 4);
        instr(JAL, 1'b1, 0, 0, n); check("len_jal", n, 4);
        instr(SW, 1'b0, 0, 1, n);  check("len_sw_stall1", n, 5);
        // sw aborted by a 2-cycle reset while MEMWRITE is stalled
        push(1'b0, 7'h7f, 1'b0, 1'b1, 4'd0);
        push(1'b0, SW, 1'b0, 1'b1, 4'd1);
        push(1'b0, SW, 1'b0, 1'b1, 4'd2);
        push(1'b0, 7'h7f, 1'b0, 1'b0, 4'd5);
        push(1'b0, 7'h7f, 1'b0, 1'b0, 4'd5);
        push(1'b1, 7'h7f, 1'b0, 1'b1, 4'd5);
        push(1'b1, 7'h7f, 1'b0, 1'b1, 4'd0);
        instr(RR, 1'b1, 0, 0, n);
        instr(7'h7f, 1'b1, 0, 0, n);
        instr(LW, 1'b1, 0, 0, n);  check("len_lw", n, 5);
        instr(SW, 1'b1, 0, 0, n);  check("len_sw", n, 4);
        pin.r = 1'b0; pin.o = BEQ; pin.z = 1'b1; pin.mr = 1'b0; pin.st = 4'd10;
        check("model_beq_taken_vec", int'(exp_out(pin)), int'(15'b100000100001010));

        retired = 0;
        illegals = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < trace.size(); i++) begin
            rst = trace[i].r;
            op = trace[i].o;
            Zero = trace[i].z;
            mem_ready = trace[i].mr;
            @(negedge clk);
            act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
                   RegWrite, instr_done, illegal_op};
            exp = exp_out(trace[i]);
            total++;
            if (act != exp) begin
                bad++;
                $display("FAIL outputs cycle %0d state %0d: got %h expected %h",
                         i, trace[i].st, act, exp);
            end
            check($sformatf("state_cycle%0d", i), int'(state_o), int'(trace[i].st));
            if (instr_done) retired++;
            if (illegal_op) illegals++;
            @(posedge clk);
            #1;
        end
        check("retired_count", retired, 11);
        check("illegal_count", illegals, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
